codificador_flip_bloque: RTL and testbench

- Bus-invert encoder: the transmit-side counterpart of the per-lane conditional-inversion datapath.
- For each of M N-bit lanes, compares the new word against the last word actually driven on that lane.
- If more than N/2 bits would toggle, it drives the inverted word and raises the lane's flip flag.
- Output is registered with a valid/ready stream handshake; the receive side restores data by applying f per lane.

---
 rtl/codificador_flip_pkg.sv | 23 ++
 rtl/decisor_flip_uno.sv | 24 ++
 rtl/codificador_flip_bloque.sv | 92 +++++++++
 tb/tb_codificador_flip_bloque.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codificador_flip_pkg.sv
// Shared constants and helpers for the bus-invert encoder.
package codificador_flip_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_M     = 16;
    localparam int unsigned DEF_CW    = 32;
    localparam int unsigned POP_MAX_W = 256;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned hd_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] x);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + 32'(x[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/decisor_flip_uno.sv
// Per-lane flip decision: invert when more than half the bits would toggle.
module decisor_flip_uno
    import codificador_flip_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] prev,
    input  logic         en,
    output logic [N-1:0] b_next,
    output logic         flip
);
    localparam int unsigned HD_W = hd_width(N);

    logic [HD_W-1:0] hd;

    // Tie at exactly N/2 keeps the word uninverted.
    always_comb begin
        hd     = HD_W'(popcount(POP_MAX_W'(a ^ prev)));
        flip   = en && (hd > HD_W'(N / 2));
        b_next = flip ? ~a : a;
    end

endmodule

// File: rtl/codificador_flip_bloque.sv
// Bus-invert encoder for M lanes with a single-stage valid/ready output register.
module codificador_flip_bloque
    import codificador_flip_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned M  = DEF_M,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a [M-1:0],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  b [M-1:0],
    output logic [M-1:0]  f,
    output logic [CW-1:0] flip_count
);
    localparam int unsigned FC_W  = hd_width(M);
    localparam int unsigned SUM_W = ((CW > FC_W) ? CW : FC_W) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N-1:0]    prev_q [M-1:0];
    logic [N-1:0]    b_q    [M-1:0];
    logic [N-1:0]    b_d    [M-1:0];
    logic [M-1:0]    f_q;
    logic [M-1:0]    f_d;
    logic            out_valid_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [FC_W-1:0] flip_total;
    logic [SUM_W-1:0] cnt_sum;
    logic            accept;

    for (genvar i = 0; i < M; i++) begin : g_lane
        decisor_flip_uno #(.N(N)) u_decisor (
            .a      (a[i]),
            .prev   (prev_q[i]),
            .en     (en),
            .b_next (b_d[i]),
            .flip   (f_d[i])
        );
    end

    assign in_ready = !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Saturating add of this block's flipped lanes.
    always_comb begin
        flip_total = FC_W'(popcount(POP_MAX_W'(f_d)));
        cnt_sum    = SUM_W'(cnt_q) + SUM_W'(flip_total);
        cnt_d      = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CW'(cnt_sum);
    end

    // History tracks the driven word; clr wipes history but leaves b/f as last driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                prev_q[i] <= '0;
                b_q[i]    <= '0;
            end
            f_q         <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (clr) begin
            for (int i = 0; i < M; i++) begin
                prev_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (accept) begin
            for (int i = 0; i < M; i++) begin
                prev_q[i] <= b_d[i];
                b_q[i]    <= b_d[i];
            end
            f_q         <= f_d;
            out_valid_q <= 1'b1;
            cnt_q       <= cnt_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign b          = b_q;
    assign f          = f_q;
    assign out_valid  = out_valid_q;
    assign flip_count = cnt_q;

endmodule

// File: tb/tb_codificador_flip_bloque.sv
// Randomized and directed checks of the bus-invert encoder against a behavioural model.
module tb_codificador_flip_bloque;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a [1:0];
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] b [1:0];
    logic [1:0]  f;
    logic [31:0] flip_count;

    logic        clr2 = 1'b0;
    logic        en2 = 1'b1;
    logic        iv2 = 1'b0;
    logic        ir2;
    logic [4:0]  a2 [3:0];
    logic        ov2;
    logic        or2 = 1'b1;
    logic [4:0]  b2 [3:0];
    logic [3:0]  f2;
    logic [2:0]  cnt2;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] p;
        logic        en;
    } sb_ent_t;

    sb_ent_t     sbq [$];
    logic [15:0] m_prev [2];
    logic [15:0] m_b [2];
    logic [1:0]  m_f;
    logic        m_ov;
    longint      m_cnt;

    always #5 clk = ~clk;

    codificador_flip_bloque #(.N(16), .M(2), .CW(32)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready),
        .b(b), .f(f), .flip_count(flip_count)
    );

    codificador_flip_bloque #(.N(5), .M(4), .CW(3)) dut2 (
        .clk(clk), .rst(rst), .clr(clr2), .en(en2),
        .in_valid(iv2), .in_ready(ir2), .a(a2),
        .out_valid(ov2), .out_ready(or2),
        .b(b2), .f(f2), .flip_count(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference: encode each accepted block lane by lane from the last driven word.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev[0] = '0; m_prev[1] = '0;
            m_b[0] = '0; m_b[1] = '0;
            m_f = '0; m_ov = 0; m_cnt = 0;
            sbq.delete();
        end else if (clr) begin
            m_prev[0] = '0; m_prev[1] = '0;
            m_cnt = 0; m_ov = 0;
            sbq.delete();
        end else if (in_valid && (!m_ov || out_ready)) begin
            sb_ent_t e;
            int nflip;
            e.a = {a[1], a[0]};
            e.p = {m_prev[1], m_prev[0]};
            e.en = en;
            nflip = 0;
            for (int i = 0; i < 2; i++) begin
                int hd;
                bit fl;
                hd = $countones(a[i] ^ m_prev[i]);
                fl = en && (hd > 8);
                m_b[i] = fl ? ~a[i] : a[i];
                m_f[i] = fl;
                m_prev[i] = m_b[i];
                nflip += int'(fl);
            end
            m_cnt = m_cnt + nflip;
            if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
            m_ov = 1;
            sbq.push_back(e);
        end else if (out_ready) begin
            m_ov = 0;
        end
    end

    // Cycle compare plus decode scoreboard on every output transfer.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("in_ready", 32'(in_ready), 32'(!clr && (!m_ov || out_ready)));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("b0", 32'(b[0]), 32'(m_b[0]));
            chk("b1", 32'(b[1]), 32'(m_b[1]));
            chk("f", 32'(f), 32'(m_f));
            chk("flip_count", flip_count, m_cnt[31:0]);
            if (out_valid && out_ready && !clr) begin
                if (sbq.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    sb_ent_t e;
                    e = sbq.pop_front();
                    for (int i = 0; i < 2; i++) begin
                        logic [15:0] ew, ep, dec;
                        ew = e.a[16*i +: 16];
                        ep = e.p[16*i +: 16];
                        dec = b[i] ^ {16{f[i]}};
                        chk("sb_decode", 32'(dec), 32'(ew));
                        if (e.en) chk("sb_toggle_le_half", 32'($countones(b[i] ^ ep) <= 8), 32'd1);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w1, input logic [15:0] w0, input logic e);
        a[1] = w1; a[0] = w0; en = e; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [4:0] w);
        for (int i = 0; i < 4; i++) a2[i] = w;
        iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [15:0] e1, input logic [15:0] e0,
                       input logic [1:0] ef, input logic [31:0] ec);
        @(negedge clk);
        chk({nm, "_b1"}, 32'(b[1]), 32'(e1));
        chk({nm, "_b0"}, 32'(b[0]), 32'(e0));
        chk({nm, "_f"}, 32'(f), 32'(ef));
        chk({nm, "_cnt"}, flip_count, ec);
        step();
    endtask

    task automatic lit2(input string nm, input logic [4:0] eb, input logic [3:0] ef, input logic [2:0] ec);
        chk({nm, "_b0"}, 32'(b2[0]), 32'(eb));
        chk({nm, "_b3"}, 32'(b2[3]), 32'(eb));
        chk({nm, "_f"}, 32'(f2), 32'(ef));
        chk({nm, "_cnt"}, 32'(cnt2), 32'(ec));
        chk({nm, "_ov"}, 32'(ov2), 32'd1);
        step();
    endtask

    initial begin
        a[0] = '0; a[1] = '0;
        for (int i = 0; i < 4; i++) a2[i] = '0;
        #12 rst = 1'b0;
        step();
        chk_on = 1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_b", 32'({b[1], b[0]}), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_cnt", flip_count, 32'd0);

        send(16'hFFFF, 16'h00FF, 1'b1);
        lit("blk1", 16'h0000, 16'h00FF, 2'b10, 32'd1);
        send(16'h0000, 16'hFF00, 1'b1);
        lit("blk2", 16'h0000, 16'h00FF, 2'b01, 32'd2);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ov", 32'(out_valid), 32'd0);
        chk("clr_cnt", flip_count, 32'd0);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        lit("en0", 16'hFFFF, 16'hFFFF, 2'b00, 32'd0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        lit("en1_same", 16'hFFFF, 16'hFFFF, 2'b00, 32'd0);

        // Backpressure: a second block waits while the first is held.
        out_ready = 1'b0;
        send(16'h1234, 16'h5678, 1'b1);
        a[1] = 16'hAAAA; a[0] = 16'h5555; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_dec1", 32'(b[1] ^ {16{f[1]}}), 32'h1234);
        end
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_dec_next1", 32'(b[1] ^ {16{f[1]}}), 32'hAAAA);
        chk("bp_dec_next0", 32'(b[0] ^ {16{f[0]}}), 32'h5555);
        step();

        // Asynchronous reset between edges while a block is held.
        out_ready = 1'b0;
        send(16'h0F0F, 16'hF0F0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_b", 32'({b[1], b[0]}), 32'd0);
        chk("arst_f", 32'(f), 32'd0);
        chk("arst_cnt", flip_count, 32'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        step();
        send(16'hFFFF, 16'h00FF, 1'b1);
        lit("post_rst", 16'h0000, 16'h00FF, 2'b10, 32'd1);

        // Odd width, saturating 3-bit counter, clr priority.
        send2(5'b11111);
        lit2("s1", 5'b00000, 4'hF, 3'd4);
        @(negedge clk);
        send2(5'b00111);
        lit2("s2", 5'b11000, 4'hF, 3'd7);
        @(negedge clk);
        send2(5'b00011);
        lit2("s3", 5'b11100, 4'hF, 3'd7);
        @(negedge clk);
        send2(5'b11110);
        lit2("s4", 5'b11110, 4'h0, 3'd7);
        @(negedge clk);
        send2(5'b11000);
        lit2("s5_tie2", 5'b11000, 4'h0, 3'd7);
        clr2 = 1'b1;
        iv2 = 1'b1;
        #1;
        chk("s_clr_ir", 32'(ir2), 32'd0);
        step();
        clr2 = 1'b0;
        iv2 = 1'b0;
        chk("s_clr_ov", 32'(ov2), 32'd0);
        chk("s_clr_cnt", 32'(cnt2), 32'd0);
        chk("s_clr_bhold", 32'(b2[0]), 32'(5'b11000));
        send2(5'b11111);
        lit2("s6", 5'b00000, 4'hF, 3'd4);

        // Random traffic with occasional clear.
        for (int c = 0; c < 30000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 4) != 0);
            clr       = ($urandom_range(0, 199) == 0);
            a[0] = 16'($urandom);
            a[1] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[0] = ~m_prev[0] ^ 16'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
